// File: rtl/pcs_pkg.sv
// Shared PCS constants and the transmit gearbox state type.
package pcs_pkg;

  localparam int BLOCK_W = 66;
  localparam int LANE_W  = 32;
  localparam int BUF_W   = 128;
  localparam int CNT_W   = 8;

  // Highest fill level that still leaves room for one more whole block.
  localparam int READY_MAX = BUF_W - BLOCK_W;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } tx_gb_state_t;

endpackage

// File: rtl/tx_gearbox.sv
// 66-bit block to 32-bit lane gearbox: blocks are packed LSB-first into a
// shift buffer and drained one 32-bit word per lane_ready cycle.
module tx_gearbox
  import pcs_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic [BLOCK_W-1:0]  data_in,
  input  logic                valid_in,
  output logic                ready_out,
  input  logic                lane_ready,
  output logic [LANE_W-1:0]   data_out,
  output logic                valid_out,
  output logic                underrun,
  output logic                state_dbg,
  output logic [CNT_W-1:0]    cnt_dbg
);

  // Handshake: a block transfers on any rising edge where valid_in && ready_out;
  // ready_out never looks at valid_in, and a word leaves whenever lane_ready
  // is high and at least one full lane word is buffered.

  tx_gb_state_t       state, state_next;
  logic [BUF_W-1:0]   buf_q;
  logic [BUF_W-1:0]   buf_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_after;
  logic [CNT_W-1:0]   cnt_next;
  logic               emit;
  logic               accept;

  assign emit      = lane_ready && (cnt >= CNT_W'(LANE_W));
  assign cnt_after = emit ? (cnt - CNT_W'(LANE_W)) : cnt;
  assign ready_out = (cnt_after <= CNT_W'(READY_MAX));
  assign accept    = valid_in && ready_out;
  assign cnt_next  = cnt_after + (accept ? CNT_W'(BLOCK_W) : CNT_W'(0));

  // Bits above cnt are always zero, so the new block can simply be ORed in
  // directly above whatever survives this cycle's drain.
  always_comb begin
    buf_next = emit ? (buf_q >> LANE_W) : buf_q;
    if (accept) begin
      buf_next = buf_next | ({{(BUF_W-BLOCK_W){1'b0}}, data_in} << cnt_after);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (emit) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q     <= '0;
      cnt       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      buf_q     <= buf_next;
      cnt       <= cnt_next;
      valid_out <= emit;
      if (emit) begin
        data_out <= buf_q[LANE_W-1:0];
      end
      // Start-up shortfall in FILL is expected and never flagged.
      underrun <= (state == RUN) && lane_ready && (cnt < CNT_W'(LANE_W));
    end
  end

  assign state_dbg = state;
  assign cnt_dbg   = cnt;

endmodule
